pwm_capture: RTL and testbench

- Multi-channel PWM input-capture device on the pi1 peripheral bus; the measurement-side neighbour of the PWM generator.
- Synchronises each external pulse input and measures, per channel, the period (rising edge to rising edge) and high time in clk_i cycles.
- Software selects a channel and reads the latched measurements; typical use is closed-loop checking of generated PWM or reading external PWM sensors.

---
 rtl/pwm_capture_if.sv | 26 ++
 rtl/pwm_capture.sv | 126 ++++++++++++
 tb/tb_pwm_capture.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pi1 peripheral bus bundle for the PWM capture block.
// The master drives op/addr/data/sel; the slave returns registered data,
// ready and the size of its address map.
interface pwm_capture_if #(
    parameter int ARCHBITSZ = 32
);
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);

    logic [1:0]             pi1_op_i;
    logic [ADDRBITSZ-1:0]   pi1_addr_i;
    logic [ARCHBITSZ-1:0]   pi1_data_i;
    logic [ARCHBITSZ-1:0]   pi1_data_o;
    logic [ARCHBITSZ/8-1:0] pi1_sel_i;
    logic                   pi1_rdy_o;
    logic [ADDRBITSZ-1:0]   pi1_mapsz_o;

    modport master (
        output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
        input  pi1_data_o, pi1_rdy_o, pi1_mapsz_o
    );

    modport slave (
        input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
        output pi1_data_o, pi1_rdy_o, pi1_mapsz_o
    );
endinterface

// File: rtl/pwm_capture.sv
// Multi-channel PWM input capture on the pi1 bus.
// Each channel synchronises its pulse input and latches the period
// (rise to rise) and high time in clk_i cycles. Software selects a
// channel with a command, then reads period (op 10) or high time (op 01),
// each returned as {valid, stall, count}.
module pwm_capture #(
    parameter int CAP_COUNT = 8,
    parameter int CLKFREQ   = 1,
    parameter int ARCHBITSZ = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pwm_capture_if.slave         pi1,
    input  logic [CAP_COUNT-1:0] cap_i
);
    localparam int CNTBITSZ  = ARCHBITSZ - 2;
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
    localparam int SELW      = (CAP_COUNT > 1) ? $clog2(CAP_COUNT) : 1;
    // Read views are padded to a power of two so any sel value indexes
    // a defined entry; slots past CAP_COUNT read as zero.
    localparam int NSLOT     = 1 << SELW;
    localparam logic [CNTBITSZ-1:0] CNT_MAX = {CNTBITSZ{1'b1}};

    logic [ARCHBITSZ-1:0] data_o_reg;
    logic [SELW-1:0]      sel_reg;
    logic                 cmd_clear;
    logic [ARCHBITSZ-1:0] rd_period [NSLOT];
    logic [ARCHBITSZ-1:0] rd_high   [NSLOT];
    logic                 unused_bits;

    assign cmd_clear       = (pi1.pi1_op_i == 2'b11) && (pi1.pi1_data_i[1:0] == 2'b01);
    assign pi1.pi1_data_o  = data_o_reg;
    assign pi1.pi1_rdy_o   = 1'b1;
    assign pi1.pi1_mapsz_o = ADDRBITSZ'(1);
    // Address, byte selects and upper command bits carry no meaning here.
    assign unused_bits = ^{pi1.pi1_addr_i, pi1.pi1_sel_i, pi1.pi1_data_i[ARCHBITSZ-1:SELW+2]};

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < CAP_COUNT) begin : g_ch
                logic [2:0]          sync_reg;   // [1:0] synchroniser, [2] delayed copy
                logic [CNTBITSZ-1:0] r_reg, h_reg, period_reg, high_reg;
                logic                armed_reg, valid_reg, stall_reg;
                logic                s, rise, clr;
                logic [CNTBITSZ-1:0] r_inc, h_inc;

                assign s     = sync_reg[1];
                assign rise  = s & ~sync_reg[2];
                assign clr   = cmd_clear && (sel_reg == SELW'(gi));
                assign r_inc = (r_reg == CNT_MAX) ? CNT_MAX : r_reg + CNTBITSZ'(1);
                assign h_inc = (h_reg == CNT_MAX) ? CNT_MAX : h_reg + CNTBITSZ'(s);

                // Synchronise the input and run the saturating period/high counters.
                always_ff @(posedge clk_i or negedge rst_i) begin
                    if (!rst_i) begin
                        sync_reg   <= '0;
                        r_reg      <= '0;
                        h_reg      <= '0;
                        period_reg <= '0;
                        high_reg   <= '0;
                        armed_reg  <= 1'b0;
                        valid_reg  <= 1'b0;
                        stall_reg  <= 1'b0;
                    end else begin
                        sync_reg <= {sync_reg[1:0], cap_i[gi]};
                        if (clr) begin
                            // Clear wins over a coincident edge so the channel restarts cleanly.
                            r_reg      <= '0;
                            h_reg      <= '0;
                            period_reg <= '0;
                            high_reg   <= '0;
                            armed_reg  <= 1'b0;
                            valid_reg  <= 1'b0;
                            stall_reg  <= 1'b0;
                        end else if (rise) begin
                            period_reg <= r_reg;
                            high_reg   <= h_reg;
                            valid_reg  <= armed_reg & ~stall_reg;
                            armed_reg  <= 1'b1;
                            stall_reg  <= 1'b0;
                            r_reg      <= CNTBITSZ'(1);
                            h_reg      <= CNTBITSZ'(1);
                        end else begin
                            r_reg <= r_inc;
                            h_reg <= h_inc;
                            // Counter saturated while armed: no usable edge is coming.
                            if (armed_reg && (r_inc == CNT_MAX)) begin
                                stall_reg <= 1'b1;
                                valid_reg <= 1'b0;
                            end
                        end
                    end
                end

                assign rd_period[gi] = {valid_reg, stall_reg, period_reg};
                assign rd_high[gi]   = {valid_reg, stall_reg, high_reg};
            end else begin : g_empty
                assign rd_period[gi] = '0;
                assign rd_high[gi]   = '0;
            end
        end
    endgenerate

    // Decode bus ops: command (select/clear), period read, high-time read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o_reg <= '0;
            sel_reg    <= '0;
        end else begin
            case (pi1.pi1_op_i)
                2'b11: begin
                    if (pi1.pi1_data_i[1:0] == 2'b00) begin
                        sel_reg    <= pi1.pi1_data_i[SELW+1:2];
                        data_o_reg <= ARCHBITSZ'(CLKFREQ);
                    end else if (pi1.pi1_data_i[1:0] == 2'b01) begin
                        data_o_reg <= '0;
                    end
                end
                2'b10:   data_o_reg <= rd_period[sel_reg];
                2'b01:   data_o_reg <= rd_high[sel_reg];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: an 8-channel instance (ARCHBITSZ=8, counter max 63)
// for measurement behaviour and a 5-channel instance for out-of-range selects.
// Bus results are queued as expectations when ops are issued and compared
// once the DUT has produced them.
module tb_pwm_capture;
    localparam int FREQ_A = 100;
    localparam int FREQ_B = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cap_a;
    logic [4:0] cap_b;

    always #5 clk = ~clk;

    pwm_capture_if #(.ARCHBITSZ(8)) bus_a ();
    pwm_capture_if #(.ARCHBITSZ(8)) bus_b ();

    pwm_capture #(.CAP_COUNT(8), .CLKFREQ(FREQ_A), .ARCHBITSZ(8)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .pi1(bus_a), .cap_i(cap_a)
    );
    pwm_capture #(.CAP_COUNT(5), .CLKFREQ(FREQ_B), .ARCHBITSZ(8)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .pi1(bus_b), .cap_i(cap_b)
    );

    // Pulse sources: entries 0..7 feed dut_a, 8..12 feed dut_b.
    int   gen_per  [13];
    int   gen_high [13];
    int   gen_cnt  [13];
    bit   gen_en   [13];
    logic gen_q    [13];
    logic man      [13];

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q  [$];
    logic [7:0] got_q  [$];
    logic [7:0] mask_q [$];
    string      name_q [$];

    initial begin
        for (int c = 0; c < 13; c++) begin
            gen_q[c]   = 1'b0;
            gen_cnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < 13; c++) begin
                if (gen_en[c]) begin
                    gen_q[c]   = (gen_cnt[c] < gen_high[c]);
                    gen_cnt[c] = (gen_cnt[c] + 1 >= gen_per[c]) ? 0 : gen_cnt[c] + 1;
                end else begin
                    gen_q[c]   = 1'b0;
                    gen_cnt[c] = 0;
                end
            end
        end
    end

    always_comb begin
        cap_a = '0;
        cap_b = '0;
        for (int c = 0; c < 8; c++) cap_a[c] = gen_en[c] ? gen_q[c] : man[c];
        for (int c = 0; c < 5; c++) cap_b[c] = gen_en[c + 8] ? gen_q[c + 8] : man[c + 8];
    end

    function automatic logic [7:0] word(input bit v, input bit s, input int x);
        return {v, s, x[5:0]};
    endfunction

    // Drive one bus op for one cycle; record the expectation and the DUT result.
    task automatic issue(input bit to_b, input logic [1:0] op, input logic [7:0] data,
                         input string nm, input logic [7:0] exp, input logic [7:0] mask);
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        name_q.push_back(nm);
        if (to_b) begin
            bus_b.pi1_op_i = op; bus_b.pi1_data_i = data;
        end else begin
            bus_a.pi1_op_i = op; bus_a.pi1_data_i = data;
        end
        @(negedge clk);
        got_q.push_back(to_b ? bus_b.pi1_data_o : bus_a.pi1_data_o);
        bus_a.pi1_op_i = 2'b00; bus_a.pi1_data_i = '0;
        bus_b.pi1_op_i = 2'b00; bus_b.pi1_data_i = '0;
    endtask

    task automatic test_reset();
        logic [7:0] e, g, m; string n;
        exp_q.push_back(8'h00); got_q.push_back(bus_a.pi1_data_o); mask_q.push_back(8'hff); name_q.push_back("reset_data_a");
        exp_q.push_back(8'h00); got_q.push_back(bus_b.pi1_data_o); mask_q.push_back(8'hff); name_q.push_back("reset_data_b");
        exp_q.push_back(8'h01); got_q.push_back({7'b0, bus_a.pi1_rdy_o}); mask_q.push_back(8'hff); name_q.push_back("rdy");
        exp_q.push_back(8'h01); got_q.push_back(bus_a.pi1_mapsz_o); mask_q.push_back(8'hff); name_q.push_back("mapsz");
        issue(0, 2'b10, 8'h00, "reset_read_ch0", 8'h00, 8'hff);
        issue(0, 2'b01, 8'h00, "reset_write_ch0", 8'h00, 8'hff);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_basic();
        logic [7:0] e, g, m; string n;
        gen_per[0] = 10; gen_high[0] = 3; gen_en[0] = 1'b1;
        repeat (40) @(negedge clk);
        issue(0, 2'b11, 8'h00, "basic_select0", 8'(FREQ_A), 8'hff);
        issue(0, 2'b10, 8'h00, "basic_period", word(1, 0, 10), 8'hff);
        issue(0, 2'b01, 8'hA5, "basic_high", word(1, 0, 3), 8'hff);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_arming();
        logic [7:0] e, g, m; string n;
        issue(0, 2'b11, 8'h08, "arm_select2", 8'(FREQ_A), 8'hff);
        man[2] = 1'b1;
        repeat (3) @(negedge clk);
        man[2] = 1'b0;
        issue(0, 2'b10, 8'h00, "arm_first_edge_not_valid", 8'h00, 8'hc0);
        repeat (3) @(negedge clk);
        man[2] = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 2'b10, 8'h00, "arm_period", word(1, 0, 7), 8'hff);
        issue(0, 2'b01, 8'h00, "arm_high", word(1, 0, 3), 8'hff);
        man[2] = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_stall();
        logic [7:0] e, g, m; string n;
        issue(0, 2'b11, 8'h04, "stall_select1", 8'(FREQ_A), 8'hff);
        man[1] = 1'b1;
        repeat (70) @(negedge clk);
        issue(0, 2'b10, 8'h00, "stall_flag", word(0, 1, 0), 8'hc0);
        man[1] = 1'b0;
        repeat (3) @(negedge clk);
        man[1] = 1'b1;
        repeat (2) @(negedge clk);
        man[1] = 1'b0;
        repeat (2) @(negedge clk);
        issue(0, 2'b10, 8'h00, "stall_rearm_not_valid", 8'h00, 8'hc0);
        repeat (4) @(negedge clk);
        man[1] = 1'b1;
        repeat (5) @(negedge clk);
        issue(0, 2'b10, 8'h00, "stall_recover_period", word(1, 0, 9), 8'hff);
        issue(0, 2'b01, 8'h00, "stall_recover_high", word(1, 0, 2), 8'hff);
        man[1] = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_clear_vs_edge();
        logic [7:0] e, g, m; string n;
        gen_en[0] = 1'b0;
        man[0]    = 1'b0;
        repeat (12) @(negedge clk);
        issue(0, 2'b11, 8'h00, "clr_select0", 8'(FREQ_A), 8'hff);
        man[0] = 1'b1;
        repeat (2) @(negedge clk);
        // This CLEAR is registered on the same edge as the rise.
        issue(0, 2'b11, 8'h01, "clr_cmd_data", 8'h00, 8'hff);
        issue(0, 2'b10, 8'h00, "clr_zeroed", 8'h00, 8'hff);
        man[0] = 1'b0;
        repeat (4) @(negedge clk);
        man[0] = 1'b1;
        repeat (2) @(negedge clk);
        man[0] = 1'b0;
        issue(0, 2'b10, 8'h00, "clr_unarmed_before_edge", 8'h00, 8'hff);
        repeat (2) @(negedge clk);
        man[0] = 1'b1;
        repeat (5) @(negedge clk);
        issue(0, 2'b10, 8'h00, "clr_period", word(1, 0, 5), 8'hff);
        issue(0, 2'b01, 8'h00, "clr_high", word(1, 0, 2), 8'hff);
        man[0] = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_channels();
        logic [7:0] e, g, m; string n;
        for (int c = 0; c < 8; c++) begin
            gen_per[c] = 5 + 2 * c; gen_high[c] = 1 + (c % 3); gen_en[c] = 1'b1;
        end
        repeat (80) @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            issue(0, 2'b11, 8'(c << 2), $sformatf("ch%0d_select", c), 8'(FREQ_A), 8'hff);
            issue(0, 2'b10, 8'h00, $sformatf("ch%0d_period", c), word(1, 0, 5 + 2 * c), 8'hff);
            issue(0, 2'b01, 8'h00, $sformatf("ch%0d_high", c), word(1, 0, 1 + (c % 3)), 8'hff);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_range();
        logic [7:0] e, g, m; string n;
        for (int c = 0; c < 5; c++) begin
            gen_per[c + 8] = 6 + c; gen_high[c + 8] = 2; gen_en[c + 8] = 1'b1;
        end
        repeat (40) @(negedge clk);
        issue(1, 2'b11, 8'(6 << 2), "range_select6", 8'(FREQ_B), 8'hff);
        issue(1, 2'b10, 8'h00, "range_read_zero", 8'h00, 8'hff);
        issue(1, 2'b01, 8'h00, "range_write_zero", 8'h00, 8'hff);
        issue(1, 2'b11, 8'(6 << 2) | 8'h01, "range_clear", 8'h00, 8'hff);
        for (int c = 0; c < 5; c++) begin
            issue(1, 2'b11, 8'(c << 2), $sformatf("range_sel%0d", c), 8'(FREQ_B), 8'hff);
            issue(1, 2'b10, 8'h00, $sformatf("range_kept%0d", c), word(1, 0, 6 + c), 8'hff);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] e, g, m; string n;
        gen_per[0] = 10; gen_high[0] = 3;
        repeat (30) @(negedge clk);
        issue(0, 2'b11, 8'h00, "mid_select0", 8'(FREQ_A), 8'hff);
        issue(0, 2'b10, 8'h00, "mid_before_reset", word(1, 0, 10), 8'hff);
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(8'h00); got_q.push_back(bus_a.pi1_data_o); mask_q.push_back(8'hff); name_q.push_back("mid_async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b10, 8'h00, "mid_read_after_reset", 8'h00, 8'hff);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            tests++;
            if ((g & m) !== (e & m)) begin fails++; $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m); end
            else $display("[TB] ok %s = %h", n, g);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int c = 0; c < 13; c++) begin
            gen_en[c] = 1'b0; man[c] = 1'b0; gen_per[c] = 4; gen_high[c] = 1;
        end
        bus_a.pi1_op_i = 2'b00; bus_a.pi1_addr_i = '0; bus_a.pi1_data_i = '0; bus_a.pi1_sel_i = '0;
        bus_b.pi1_op_i = 2'b00; bus_b.pi1_addr_i = '0; bus_b.pi1_data_i = '0; bus_b.pi1_sel_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_arming();
        test_stall();
        test_clear_vs_edge();
        test_channels();
        test_range();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
